// File: rtl/hybrid_arith_pkg.sv
// Shared constants, block index helpers and FSM states for the block-carry/borrow
// arithmetic datapath (hybrid adder and hybrid subtractor).
package hybrid_arith_pkg;

  localparam int WIDTH  = 18;
  localparam int BLK_W  = 4;
  localparam int NBLK   = (WIDTH + BLK_W - 1) / BLK_W;
  localparam int LAST_W = WIDTH - (NBLK - 1) * BLK_W;
  localparam int EXT_W  = NBLK * BLK_W;
  localparam int LOW_W  = $clog2(EXT_W);
  // Wide enough to index the {bw, bin} borrow chain (NBLK + 1 entries).
  localparam int KW     = $clog2(NBLK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [KW-1:0] blk_idx_t;

  function automatic logic [LOW_W-1:0] blk_lo(input blk_idx_t k);
    return LOW_W'(k) * LOW_W'(BLK_W);
  endfunction

  function automatic logic [LOW_W-1:0] blk_hi(input blk_idx_t k);
    logic [LOW_W-1:0] hi;
    hi = blk_lo(k) + LOW_W'(BLK_W - 1);
    if (hi > LOW_W'(WIDTH - 1)) begin
      hi = LOW_W'(WIDTH - 1);
    end else begin
      hi = hi;
    end
    return hi;
  endfunction

endpackage

// File: rtl/borrow_block.sv
// Combinational W-bit block subtractor: diff = x - y - bi, bo = borrow out of the block.
module borrow_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         bi_i,
  output logic [W-1:0] diff_o,
  output logic         bo_o
);

  logic [W:0] res_s;

  // One extra bit of width so the borrow falls out as the result MSB.
  always_comb begin
    res_s = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, bi_i};
  end

  assign diff_o = res_s[W-1:0];
  assign bo_o   = res_s[W];

endmodule

// File: rtl/hybrid_subtractor_seq.sv
// Multi-cycle block-borrow subtractor: d = a - b - bin, one block per clock.
// Optional SUB_OVERFLOW_EN adds a registered signed-overflow flag (ovf_o).
module hybrid_subtractor_seq
  import hybrid_arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic [NBLK-1:0]  bw_o
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf_o
`endif
);

  state_e           state_q, state_d;
  blk_idx_t         k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             bin_q, bin_d, busy_q, busy_d, done_q, done_d;
  logic [NBLK-1:0]  bw_q, bw_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [EXT_W-1:0]  a_ext_s, b_ext_s;
  logic [LOW_W-1:0]  lo_s;
  logic [NBLK:0]     chain_s;
  logic              bi_s, is_last_s, blk_bo_s;
  logic [BLK_W-1:0]  full_diff_s;
  logic [LAST_W-1:0] last_diff_s;
  logic              full_bo_s, last_bo_s;

  assign a_ext_s   = EXT_W'(a_q);
  assign b_ext_s   = EXT_W'(b_q);
  assign lo_s      = blk_lo(k_q);
  // Entry 0 is the external borrow-in; entry k is the borrow-out of block k-1.
  assign chain_s   = {bw_q, bin_q};
  assign bi_s      = chain_s[k_q];
  assign is_last_s = (k_q == KW'(NBLK - 1));
  assign blk_bo_s  = is_last_s ? last_bo_s : full_bo_s;

  borrow_block #(.W(BLK_W)) u_full_blk (
    .x_i    (a_ext_s[lo_s +: BLK_W]),
    .y_i    (b_ext_s[lo_s +: BLK_W]),
    .bi_i   (bi_s),
    .diff_o (full_diff_s),
    .bo_o   (full_bo_s)
  );

  // The short top block borrows at its own width, not at BLK_W.
  borrow_block #(.W(LAST_W)) u_last_blk (
    .x_i    (a_q[WIDTH-1 -: LAST_W]),
    .y_i    (b_q[WIDTH-1 -: LAST_W]),
    .bi_i   (bi_s),
    .diff_o (last_diff_s),
    .bo_o   (last_bo_s)
  );

  // Next-state, operand latch and block write-back.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    bin_d   = bin_q;
    d_d     = d_q;
    bw_d    = bw_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          k_d     = {KW{1'b0}};
          a_d     = a_i;
          b_d     = b_i;
          bin_d   = bin_i;
          d_d     = {WIDTH{1'b0}};
          bw_d    = {NBLK{1'b0}};
`ifdef SUB_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (is_last_s) begin
          d_d[WIDTH-1 -: LAST_W] = last_diff_s;
        end else begin
          d_d[lo_s +: BLK_W] = full_diff_s;
        end
        bw_d[k_q] = blk_bo_s;
        if (is_last_s) begin
          state_d = DONE;
          k_d     = {KW{1'b0}};
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_d[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= {KW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      bin_q   <= 1'b0;
      d_q     <= {WIDTH{1'b0}};
      bw_q    <= {NBLK{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bin_q   <= bin_d;
      d_q     <= d_d;
      bw_q    <= bw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = d_q;
  assign bw_o   = bw_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_hybrid_subtractor_seq.sv
// Scoreboard bench for hybrid_subtractor_seq: stimulus pushes reference results,
// a monitor pops and compares them whenever done is seen.
module tb_hybrid_subtractor_seq;
  import hybrid_arith_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             bin_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o, done_o;
  logic [WIDTH-1:0] d_o;
  logic [NBLK-1:0]  bw_o;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_o;
`endif

  hybrid_subtractor_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .d_o     (d_o),
    .bw_o    (bw_o)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [17:0] d;
    logic [4:0]  bw;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: 18-bit subtract done as 4,4,4,4,2-bit chunks with plain integer math.
  function automatic exp_t ref_sub(logic [17:0] a, logic [17:0] b, logic bin, int due);
    exp_t e;
    int   br, lo, w, m, x, y, r;
    br = int'(bin);
    e.d = '0;
    e.bw = '0;
    for (int k = 0; k < 5; k++) begin
      lo = 4 * k;
      w  = (18 - lo < 4) ? (18 - lo) : 4;
      m  = (1 << w) - 1;
      x  = int'(a >> lo) & m;
      y  = int'(b >> lo) & m;
      r  = x - y - br;
      br = (r < 0) ? 1 : 0;
      e.bw[k] = br[0];
      e.d = e.d | 18'((r & m) << lo);
    end
    e.ovf = (a[17] != b[17]) && (e.d[17] != a[17]);
    e.due = due;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_latency", cyc, mon_e.due);
        chk("d", d_o, mon_e.d);
        chk("bw", bw_o, mon_e.bw);
`ifdef SUB_OVERFLOW_EN
        chk("ovf", ovf_o, mon_e.ovf);
`endif
      end
    end
  end

  task automatic do_op(input logic [17:0] a, input logic [17:0] b, input logic bin,
                       input bit glitch);
    @(negedge clk);
    a_i = a; b_i = b; bin_i = bin; start_i = 1'b1;
    sb_q.push_back(ref_sub(a, b, bin, cyc + 6));
    @(negedge clk);
    start_i = 1'b0;
    a_i = 18'($urandom()); b_i = 18'($urandom());
    chk("busy_after_start", busy_o, 1);
    chk("d_cleared", d_o, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("busy_run", busy_o, 1);
      if (glitch && i == 2) begin
        start_i = 1'b1; a_i = 18'($urandom()); b_i = 18'($urandom()); bin_i = ~bin;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("busy_in_done", busy_o, 1);
    @(negedge clk);
    chk("busy_fall", busy_o, 0);
    chk("done_one_cycle", done_o, 0);
  endtask

  task automatic b2b(input logic [17:0] a0, input logic [17:0] b0,
                     input logic [17:0] a1, input logic [17:0] b1);
    int c0;
    @(negedge clk);
    c0 = cyc;
    a_i = a0; b_i = b0; bin_i = 1'b0; start_i = 1'b1;
    sb_q.push_back(ref_sub(a0, b0, 1'b0, c0 + 6));
    repeat (6) @(negedge clk);
    a_i = a1; b_i = b1; bin_i = 1'b1;
    sb_q.push_back(ref_sub(a1, b1, 1'b1, c0 + 13));
    @(negedge clk);
    chk("b2b_idle_gap", busy_o, 0);
    @(negedge clk);
    chk("b2b_second_accept", busy_o, 1);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("b2b_end_idle", busy_o, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_d"}, d_o, 0);
    chk({tag, "_bw"}, bw_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, ovf_o, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    do_op(18'd128, 18'd128, 1'b0, 1'b0);
    do_op(18'd0, 18'd1, 1'b0, 1'b0);
    do_op(18'd200, 18'd56, 1'b1, 1'b0);
    do_op(18'd200, 18'd56, 1'b1, 1'b1);
    do_op(18'h1FFFF, 18'h3FFFF, 1'b0, 1'b0);
    do_op(18'd5, 18'd3, 1'b0, 1'b0);
    do_op(18'h3FFFF, 18'h00000, 1'b1, 1'b0);
    do_op(18'h00000, 18'h3FFFF, 1'b1, 1'b0);

    // Reset asserted while block 2 is about to be computed.
    @(negedge clk);
    a_i = 18'd0; b_i = 18'd1; bin_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset_idle");
    do_op(18'd0, 18'd1, 1'b0, 1'b0);

    b2b(18'd1000, 18'd999, 18'h20000, 18'h1FFFF);

    for (int n = 0; n < 40; n++) begin
      do_op(18'($urandom()), 18'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
